// File: rtl/uart_arb_pkg.sv
// Shared types and width helpers for the UART transmit arbiter.
// The state encoding, requester-index width and timeout-counter width live here.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    START   = 3'd2,
    WAIT_HI = 3'd3,
    WAIT_LO = 3'd4
  } arb_state_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int tmo_width(input int t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction

  localparam int NUM_REQ_DEF = 4;
  localparam int ID_W        = id_width(NUM_REQ_DEF);

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin selector: first set bit of req strictly after ptr, wrapping.
// Purely combinational; any is low when no request bit is set.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]           req,
  input  logic [id_width(NUM_REQ)-1:0] ptr,
  output logic [id_width(NUM_REQ)-1:0] winner,
  output logic                         any
);

  localparam int IDW = id_width(NUM_REQ);

  int idx;

  // Scan from the farthest offset down so the nearest valid index wins last.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = (int'(ptr) + off) % NUM_REQ;
      if (req[idx]) begin
        winner = IDW'(idx);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one byte-wide UART TX core among NUM_REQ requesters with round-robin,
// burst-locked grants, a start/busy handshake and a sticky busy-timeout flag.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 8,
  parameter int MAX_BURST    = 16,
  parameter int BUSY_TIMEOUT = 1023
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         tx_start,
  output logic [DATA_W-1:0]            tx_data,
  input  logic                         tx_busy,
  output logic [id_width(NUM_REQ)-1:0] grant_id,
  output logic                         active,
  output logic                         timeout_err
);

  localparam int              IDW       = id_width(NUM_REQ);
  localparam int              TW        = tmo_width(BUSY_TIMEOUT);
  localparam logic [TW-1:0]   TMO_MAX   = TW'(BUSY_TIMEOUT);
  localparam logic [7:0]      BURST_MAX = 8'(MAX_BURST);

  arb_state_e        state_q, state_d;
  logic [IDW-1:0]    grant_id_q, grant_id_d;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [7:0]        byte_cnt_q, byte_cnt_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic              timeout_err_q, timeout_err_d;

  logic [IDW-1:0]    pick_id;
  logic              pick_any;
  logic [TW-1:0]     tmo_inc;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .winner (pick_id),
    .any    (pick_any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_id_q    <= '0;
      rr_ptr_q      <= IDW'(NUM_REQ - 1);
      byte_cnt_q    <= '0;
      last_q        <= 1'b0;
      tx_data_q     <= '0;
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_id_q    <= grant_id_d;
      rr_ptr_q      <= rr_ptr_d;
      byte_cnt_q    <= byte_cnt_d;
      last_q        <= last_d;
      tx_data_q     <= tx_data_d;
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Saturating increment: the timeout counter never wraps back to zero.
  assign tmo_inc = (tmo_cnt_q == TMO_MAX) ? tmo_cnt_q : tmo_cnt_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    rr_ptr_d      = rr_ptr_q;
    byte_cnt_d    = byte_cnt_q;
    last_d        = last_q;
    tx_data_d     = tx_data_q;
    tmo_cnt_d     = tmo_cnt_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_id_d = pick_id;
          byte_cnt_d = '0;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        tx_data_d  = req_data[int'(grant_id_q)*DATA_W +: DATA_W];
        last_d     = req_last[grant_id_q];
        byte_cnt_d = byte_cnt_q + 8'd1;
        state_d    = START;
      end
      START: begin
        tmo_cnt_d = '0;
        state_d   = WAIT_HI;
      end
      WAIT_HI: begin
        if (tx_busy) begin
          state_d = WAIT_LO;
        end else begin
          tmo_cnt_d = tmo_inc;
          if (tmo_inc == TMO_MAX) begin
            timeout_err_d = 1'b1;
            rr_ptr_d      = grant_id_q;
            state_d       = IDLE;
          end
        end
      end
      WAIT_LO: begin
        // A burst ends on its last byte, at the burst cap, or when the grantee goes quiet.
        if (!tx_busy) begin
          if (last_q || (byte_cnt_q == BURST_MAX) || !req_valid[grant_id_q]) begin
            rr_ptr_d = grant_id_q;
            state_d  = IDLE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state_q == LOAD) req_ready[grant_id_q] = 1'b1;
    tx_start    = (state_q == START);
    active      = (state_q != IDLE);
    tx_data     = tx_data_q;
    grant_id    = grant_id_q;
    timeout_err = timeout_err_q;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues feed bytes, a TX-core
// model answers tx_start, and expected (grantee, byte) pairs are checked on each start.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 16;
  localparam int BT = 1023;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } src_t;

  typedef struct {
    int            id;
    logic [DW-1:0] d;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]    req_last = '0;
  logic [NR-1:0]    req_ready;
  logic             tx_start;
  logic [DW-1:0]    tx_data;
  logic             tx_busy = 1'b0;
  logic [1:0]       grant_id;
  logic             active;
  logic             timeout_err;

  uart_tx_arbiter #(
    .NUM_REQ      (NR),
    .DATA_W       (DW),
    .MAX_BURST    (MB),
    .BUSY_TIMEOUT (BT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .active      (active),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   n_starts = 0;
  int   last_ready_cyc = 0;
  int   last_start_cyc = 0;
  int   valid_cyc [NR];
  src_t src_q [NR][$];
  exp_t exp_q [$];
  logic tx_mode_on = 1'b1;
  int   busy_len = 10;
  logic model_act = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic push_src(input int i, input logic [DW-1:0] d, input logic l);
    src_t s;
    s.d = d;
    s.l = l;
    src_q[i].push_back(s);
  endtask

  task automatic push_exp(input int id, input logic [DW-1:0] d);
    exp_t e;
    e.id = id;
    e.d  = d;
    exp_q.push_back(e);
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NR; i++) begin
      if (src_q[i].size() > 0) begin
        if (!req_valid[i]) valid_cyc[i] = cyc;
        req_valid[i]         = 1'b1;
        req_data[i*DW +: DW] = src_q[i][0].d;
        req_last[i]          = src_q[i][0].l;
      end else begin
        req_valid[i]         = 1'b0;
        req_data[i*DW +: DW] = '0;
        req_last[i]          = 1'b0;
      end
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Requester models: a byte leaves its queue on the edge where valid & ready.
  initial begin
    logic [NR-1:0] xfer;
    drive_inputs();
    forever begin
      @(negedge clk);
      xfer = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++)
        if (xfer[i] === 1'b1 && src_q[i].size() > 0) void'(src_q[i].pop_front());
      drive_inputs();
    end
  end

  // TX core model: busy rises two cycles after the start pulse and holds busy_len cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1 && !reset && tx_mode_on) begin
        model_act = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 tx_busy = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1 tx_busy = 1'b0;
        model_act = 1'b0;
      end
    end
  end

  // Output monitor: every start pulse is matched against the scoreboard head.
  always @(negedge clk) begin
    if (!reset) begin
      if (req_ready != '0) begin
        check_eq("rdy_onehot", $countones(req_ready), 1);
        last_ready_cyc = cyc;
      end
      if (tx_start === 1'b1) begin
        n_starts++;
        last_start_cyc = cyc;
        if (exp_q.size() == 0) begin
          check_eq("unexpected_start", {24'd0, tx_data}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_eq("tx_data", {24'd0, tx_data}, {24'd0, e.d});
          check_eq("grant_id", {30'd0, grant_id}, e.id);
        end
      end
    end
  end

  task automatic wait_model_idle();
    int n = 0;
    while ((model_act || tx_busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_reset();
    wait_model_idle();
    for (int i = 0; i < NR; i++) src_q[i].delete();
    @(posedge clk);
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_drain(input string tag, input int bound);
    int n = 0;
    while ((exp_q.size() != 0 || active || tx_busy || model_act) && n < bound) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, n < bound, 1);
  endtask

  task automatic wait_starts(input int k, input int bound);
    int target = n_starts + k;
    int n = 0;
    while (n_starts < target && n < bound) begin
      @(negedge clk);
      n++;
    end
    check_eq("start_seen", n < bound, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"},  {28'd0, req_ready}, 0);
    check_eq({tag, "_start"},  {31'd0, tx_start}, 0);
    check_eq({tag, "_data"},   {24'd0, tx_data}, 0);
    check_eq({tag, "_grant"},  {30'd0, grant_id}, 0);
    check_eq({tag, "_active"}, {31'd0, active}, 0);
    check_eq({tag, "_tmo"},    {31'd0, timeout_err}, 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int err_cyc;
    for (int i = 0; i < NR; i++) valid_cyc[i] = 0;

    // Power-on reset.
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst");

    // Single byte, latency and active release.
    busy_len = 10;
    push_src(0, 8'h55, 1'b1);
    push_exp(0, 8'h55);
    wait_starts(1, 50);
    check_eq("lat_ready", last_ready_cyc - valid_cyc[0], 1);
    check_eq("lat_start", last_start_cyc - valid_cyc[0], 2);
    n = 0;
    while (tx_busy !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    while (tx_busy !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    check_eq("busy_fall_seen", n < 50, 1);
    check_eq("active_wait_lo", {31'd0, active}, 1);
    @(negedge clk);
    check_eq("active_release", {31'd0, active}, 0);
    wait_drain("drain_single", 100);

    // Four simultaneous single-byte requesters: order 0,1,2,3,0.
    do_reset();
    busy_len = 3;
    push_src(0, 8'hA0, 1'b1);
    push_src(0, 8'hA1, 1'b1);
    push_src(1, 8'hB0, 1'b1);
    push_src(2, 8'hC0, 1'b1);
    push_src(3, 8'hD0, 1'b1);
    push_exp(0, 8'hA0);
    push_exp(1, 8'hB0);
    push_exp(2, 8'hC0);
    push_exp(3, 8'hD0);
    push_exp(0, 8'hA1);
    wait_drain("drain_rr", 300);

    // Burst cap: requester 2 sends 16, requester 1 cuts in, then 2 resumes.
    do_reset();
    for (int b = 0; b < 20; b++) push_src(2, 8'(b), (b == 19));
    for (int b = 0; b < 16; b++) push_exp(2, 8'(b));
    push_exp(1, 8'hE1);
    for (int b = 16; b < 20; b++) push_exp(2, 8'(b));
    wait_starts(1, 50);
    push_src(1, 8'hE1, 1'b1);
    wait_drain("drain_burst", 1000);

    // Busy never rises: flag rises on the edge BT cycles after the start cycle ends.
    do_reset();
    tx_mode_on = 1'b0;
    push_src(0, 8'h77, 1'b1);
    push_src(1, 8'h88, 1'b1);
    push_exp(0, 8'h77);
    push_exp(1, 8'h88);
    wait_starts(1, 50);
    n = 0;
    while (timeout_err !== 1'b1 && n < BT + 50) begin @(negedge clk); n++; end
    err_cyc = cyc;
    check_eq("tmo_lat", err_cyc - last_start_cyc, BT + 1);
    check_eq("tmo_idle", {31'd0, active}, 0);
    wait_drain("drain_tmo", BT + 100);
    check_eq("tmo_sticky", {31'd0, timeout_err}, 1);
    tx_mode_on = 1'b1;
    do_reset();
    @(negedge clk);
    check_eq("tmo_cleared", {31'd0, timeout_err}, 0);

    // Reset while waiting for busy to fall mid-burst.
    for (int b = 0; b < 5; b++) push_src(3, 8'h90 + 8'(b), (b == 4));
    push_exp(3, 8'h90);
    push_exp(3, 8'h91);
    wait_starts(2, 100);
    n = 0;
    while (tx_busy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    check_eq("mid_active", {31'd0, active}, 1);
    @(posedge clk);
    #2 reset = 1'b1;
    src_q[3].delete();
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("mid_rst");
    @(posedge clk);
    #2 reset = 1'b0;
    exp_q.delete();
    wait_model_idle();
    push_src(3, 8'h31, 1'b1);
    push_src(0, 8'h30, 1'b1);
    push_exp(0, 8'h30);
    push_exp(3, 8'h31);
    wait_drain("drain_after_rst", 200);

    // Locked requester 3 goes quiet after two non-last bytes.
    do_reset();
    push_src(3, 8'h61, 1'b0);
    push_src(3, 8'h62, 1'b0);
    push_exp(3, 8'h61);
    push_exp(3, 8'h62);
    push_exp(0, 8'h40);
    wait_starts(1, 50);
    push_src(0, 8'h40, 1'b1);
    wait_drain("drain_drop", 300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one byte-wide UART transmitter core among NUM_REQ requesters.
- Round-robin grants with burst locking: a granted requester keeps the line until its last byte, or until MAX_BURST bytes have been sent.
- Drives the transmitter through a start/busy handshake and flags a transmitter that never responds.
- Sits between command/telemetry sources and the serial TX core, mirroring the receive path.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width.
- MAX_BURST, 16, bytes per grant before forced re-arbitration (1..255).
- BUSY_TIMEOUT, 1023, cycles allowed for tx_busy to rise after tx_start.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  per-requester byte available
- req_data  in  NUM_REQ*DATA_W  per-requester byte; requester i occupies bits [i*DATA_W +: DATA_W]
- req_last  in  NUM_REQ  byte is the final byte of the requester's burst
- req_ready  out  NUM_REQ  one-hot byte accept
- tx_start  out  1  one-cycle pulse telling the TX core to load tx_data
- tx_data  out  DATA_W  registered byte for the TX core
- tx_busy  in  1  TX core is shifting a frame
- grant_id  out  clog2(NUM_REQ)  current or most recent grantee
- active  out  1  high in every state except IDLE
- timeout_err  out  1  sticky; set when tx_busy fails to rise

Behaviour:
- Reset values:
  - state=IDLE; req_ready=0; tx_start=0; tx_data=0; grant_id=0; active=0; timeout_err=0.
  - rr pointer = NUM_REQ-1, so requester 0 wins first.
- Reset asserted mid-operation: every output returns to its reset value on the next edge. The byte in flight is abandoned. No req_ready pulse is produced.
- Handshake rules:
  - A requester holds req_valid, req_data and req_last stable until it sees req_ready.
  - A transfer occurs on the edge where req_valid[i] & req_ready[i].
- States:
  - IDLE:
    - If any req_valid, pick the first valid index after the rr pointer, wrapping modulo NUM_REQ.
    - Register grant_id, clear byte_cnt, go to LOAD.
  - LOAD:
    - req_ready[grant_id]=1 for exactly this cycle.
    - Capture req_data into tx_data and req_last into last_q; byte_cnt+=1; go to START.
  - START:
    - tx_start=1 for exactly this cycle.
    - Clear the timeout counter; go to WAIT_HI.
  - WAIT_HI:
    - On tx_busy=1, go to WAIT_LO.
    - Otherwise increment the timeout counter. When it equals BUSY_TIMEOUT, set timeout_err, set rr pointer=grant_id, and go to IDLE.
  - WAIT_LO: on tx_busy=0:
    - If last_q, or byte_cnt==MAX_BURST, or req_valid[grant_id]=0: set rr pointer=grant_id and go to IDLE.
    - Otherwise go to LOAD (lock kept).
- Latency:
  - req_valid seen in IDLE at edge k → req_ready high during cycle k+1.
  - tx_start high during cycle k+2.
  - Back-to-back locked bytes: tx_busy falling edge → req_ready on the next cycle.
- Simultaneous requests: only one grant at a time. req_ready is never multi-hot.
- Fairness: after a grant ends, the grantee has the lowest priority in the next arbitration.
- Width rules:
  - byte_cnt is 8-bit and is compared for equality only.
  - The timeout counter is clog2(BUSY_TIMEOUT+1) bits and saturates; it never wraps.
- Corner cases:
  - tx_busy already high in START: WAIT_HI exits on the next edge and a new start is not re-issued.
  - req_valid dropped by a locked requester: the burst ends and re-arbitration follows.
  - MAX_BURST=1 degenerates to per-byte round-robin.
- timeout_err is cleared only by reset.

Decomposition:
- Package uart_arb_pkg holds:
  - state enum (IDLE, LOAD, START, WAIT_HI, WAIT_LO);
  - localparam ID_W = clog2(NUM_REQ);
  - timeout counter width function.
- One combinational sub-module, rr_pick: inputs req vector and pointer; outputs winner index and any-valid flag.
- The FSM, counters and datapath stay in uart_tx_arbiter.

Test Plan:
- After reset, req_valid=4'b0001, data 0x55, last=1; TX model raises busy 2 cycles after start and holds it 10 cycles.
  → req_ready[0] pulses at k+1; tx_start at k+2 with tx_data=0x55; active returns to 0 one cycle after busy falls.
- All four valid continuously, each byte last=1.
  → grant order 0,1,2,3,0; req_ready never multi-hot.
- Requester 2 streams 20 bytes 0x00..0x13 with last on the final byte; requester 1 also valid; MAX_BURST=16.
  → bytes 0x00..0x0F go out, then requester 1 is granted, then requester 2 resumes at 0x10.
- TX model never raises busy.
  → timeout_err=1 exactly BUSY_TIMEOUT cycles after tx_start; FSM returns to IDLE; next valid requester is granted; timeout_err stays 1.
- reset pulsed while in WAIT_LO mid-burst.
  → all outputs at reset values on the next edge; rr restarts at requester 0.
- Locked requester 3 drops valid after byte 2 of a burst without last.
  → re-arbitration; requester 0 granted next if valid.
